// File: rtl/win_pkg.sv
// Shared types for the win-check sequencer.
// Direction codes, FSM states and cell encodings.
package win_pkg;

  localparam logic [1:0] DIR_H  = 2'd0;
  localparam logic [1:0] DIR_V  = 2'd1;
  localparam logic [1:0] DIR_L1 = 2'd2;
  localparam logic [1:0] DIR_L2 = 2'd3;

  localparam logic [1:0] EMPTY = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LAUNCH,
    RUN,
    FINISH
  } state_e;

  function automatic logic [3:0] dir_onehot(
    input logic [1:0] d
  );
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/win_check_sequencer_seq_timer.sv
// Saturating up-counter with clear and terminal-count compare.
// Shared between the clear hold and the checker watchdog.
module seq_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == lim_i);

endmodule

// File: rtl/win_check_sequencer.sv
// Sequences the four direction checkers over one shared
// board read port and reports win / winning direction.
module win_check_sequencer
  import win_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int CLR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pointer,
  input  logic [1:0]  chess,
  output logic        busy,
  output logic        done,
  output logic        win,
  output logic [1:0]  win_dir,
  output logic        timeout_err,
  output logic [7:0]  mem_addr,
  input  logic [1:0]  mem_data,
  output logic        chk_reset,
  output logic [3:0]  chk_active,
  output logic [7:0]  chk_pointer,
  output logic [1:0]  chk_chess,
  input  logic [31:0] chk_addr,
  output logic [1:0]  chk_currstate,
  input  logic [3:0]  chk_success,
  input  logic [3:0]  chk_fail
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] CLR_LIM = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] RUN_LIM = TW'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic        win_q, win_d;
  logic [1:0]  wdir_q, wdir_d;
  logic        terr_q, terr_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [1:0]  chess_q, chess_d;

  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_tc;
  logic [TW-1:0] tmr_lim;

  // Any state change restarts the count, so each CLEAR and
  // RUN phase begins from zero.
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (state_q == CLEAR) || (state_q == RUN);
  assign tmr_lim = (state_q == CLEAR) ? CLR_LIM : RUN_LIM;

  seq_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .lim_i (tmr_lim),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    win_d   = win_q;
    wdir_d  = wdir_q;
    terr_d  = terr_q;
    ptr_d   = ptr_q;
    chess_d = chess_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = pointer;
          chess_d = chess;
          win_d   = 1'b0;
          wdir_d  = DIR_H;
          terr_d  = 1'b0;
          dir_d   = DIR_H;
          state_d = (chess == EMPTY) ? FINISH : CLEAR;
        end
      end
      CLEAR: begin
        if (tmr_tc) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = RUN;
      end
      RUN: begin
        if (chk_success[dir_q]) begin
          win_d   = 1'b1;
          wdir_d  = dir_q;
          state_d = FINISH;
        end else if (chk_fail[dir_q] || tmr_tc) begin
          if (!chk_fail[dir_q]) terr_d = 1'b1;
          if (dir_q == DIR_L2) begin
            state_d = FINISH;
          end else begin
            dir_d   = dir_q + 2'd1;
            state_d = CLEAR;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_H;
      win_q   <= 1'b0;
      wdir_q  <= DIR_H;
      terr_q  <= 1'b0;
      ptr_q   <= '0;
      chess_q <= EMPTY;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      wdir_q  <= wdir_d;
      terr_q  <= terr_d;
      ptr_q   <= ptr_d;
      chess_q <= chess_d;
    end
  end

  logic scanning;
  assign scanning = (state_q == LAUNCH) || (state_q == RUN);

  assign busy        = (state_q == CLEAR) || scanning;
  assign done        = (state_q == FINISH);
  assign chk_reset   = !scanning;
  assign chk_active  = (state_q == LAUNCH) ? dir_onehot(dir_q) : 4'b0;
  assign mem_addr    = scanning ? chk_addr[{dir_q, 3'b000} +: 8] : 8'h00;
  assign chk_pointer = ptr_q;
  assign chk_chess   = chess_q;
  assign chk_currstate = mem_data;
  assign win         = win_q;
  assign win_dir     = wdir_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_win_check_sequencer.sv
// Bench for win_check_sequencer: behavioural checkers,
// a board model, vector table and a result scoreboard.
module tb_win_check_sequencer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pointer;
  logic [1:0]  chess;
  logic        busy, done, win, timeout_err;
  logic [1:0]  win_dir;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_data;
  logic        chk_reset;
  logic [3:0]  chk_active;
  logic [7:0]  chk_pointer;
  logic [1:0]  chk_chess;
  logic [31:0] chk_addr;
  logic [1:0]  chk_currstate;
  logic [3:0]  chk_success;
  logic [3:0]  chk_fail;

  always #5 clk = ~clk;

  win_check_sequencer #(
    .TIMEOUT    (TO),
    .CLR_CYCLES (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pointer       (pointer),
    .chess         (chess),
    .busy          (busy),
    .done          (done),
    .win           (win),
    .win_dir       (win_dir),
    .timeout_err   (timeout_err),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .chk_reset     (chk_reset),
    .chk_active    (chk_active),
    .chk_pointer   (chk_pointer),
    .chk_chess     (chk_chess),
    .chk_addr      (chk_addr),
    .chk_currstate (chk_currstate),
    .chk_success   (chk_success),
    .chk_fail      (chk_fail)
  );

  logic [1:0] board [256];
  assign mem_data = board[mem_addr];

  function automatic int dr(int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int dc(int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic bit cvalid(logic [7:0] p, int i, int k);
    int r, c;
    r = int'(p[7:4]) + k * dr(i);
    c = int'(p[3:0]) + k * dc(i);
    return (r >= 0) && (r < 16) && (c >= 0) && (c < 16);
  endfunction

  function automatic logic [7:0] caddr(logic [7:0] p, int i, int k);
    int r, c;
    r = int'(p[7:4]) + k * dr(i);
    c = int'(p[3:0]) + k * dc(i);
    return {r[3:0], c[3:0]};
  endfunction

  function automatic int first_k(logic [7:0] p, int i);
    for (int k = -4; k <= 0; k++) if (cvalid(p, i, k)) return k;
    return 0;
  endfunction

  function automatic int last_k(logic [7:0] p, int i);
    for (int k = 4; k >= 0; k--) if (cvalid(p, i, k)) return k;
    return 0;
  endfunction

  // Behavioural direction checkers: one cell per cycle,
  // success on the fifth consecutive match.
  bit         ck_run [4];
  int         ck_k   [4];
  int         ck_end [4];
  int         ck_cnt [4];
  logic [3:0] succ, fail;
  bit         stall2;

  assign chk_success = succ;
  assign chk_fail    = fail;

  always @* begin
    chk_addr = '0;
    for (int i = 0; i < 4; i++)
      chk_addr[8*i +: 8] = ck_run[i] ?
        caddr(chk_pointer, i, ck_k[i]) : chk_pointer;
  end

  always @(posedge clk) begin
    if (chk_reset) begin
      for (int i = 0; i < 4; i++) ck_run[i] <= 1'b0;
      succ <= '0;
      fail <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (chk_active[i]) begin
          ck_run[i] <= 1'b1;
          ck_k[i]   <= first_k(chk_pointer, i);
          ck_end[i] <= last_k(chk_pointer, i);
          ck_cnt[i] <= 0;
        end else if (ck_run[i] && !(stall2 && i == 2)) begin
          if (chk_currstate == chk_chess) begin
            ck_cnt[i] <= ck_cnt[i] + 1;
            if (ck_cnt[i] >= 4) begin
              succ[i]   <= 1'b1;
              ck_run[i] <= 1'b0;
            end
          end else begin
            ck_cnt[i] <= 0;
          end
          if (ck_k[i] == ck_end[i] &&
              !(chk_currstate == chk_chess && ck_cnt[i] >= 4)) begin
            fail[i]   <= 1'b1;
            ck_run[i] <= 1'b0;
          end
          ck_k[i] <= ck_k[i] + 1;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] ptr;
    logic [1:0] chess;
    logic [7:0] line0;
    int         ldir;
    int         llen;
    bit         stall;
    bit         exp_win;
    logic [1:0] exp_dir;
    bit         exp_to;
    int         exp_lat;
  } vec_t;

  vec_t       vecs [11];
  vec_t       sb [$];
  logic [3:0] act_log [$];
  int         act_cyc [$];
  logic [7:0] addr_log [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int done_cnt = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vec_t e;
    int   na;
    if (chk_active != 4'b0) begin
      act_log.push_back(chk_active);
      act_cyc.push_back(cyc);
    end
    if (busy) addr_log.push_back(mem_addr);
    if (done) begin
      done_cnt++;
      check("done mem_addr", mem_addr, 8'h00);
      check("done chk_reset", chk_reset, 1'b1);
      check("done busy", busy, 1'b0);
      if (sb.size() == 0) begin
        check("spurious done", done, 1'b0);
      end else begin
        e = sb.pop_front();
        check("win", win, e.exp_win);
        check("win_dir", win_dir, e.exp_dir);
        check("timeout_err", timeout_err, e.exp_to);
        na = (e.chess == 2'd0) ? 0 :
             (e.exp_win ? int'(e.exp_dir) + 1 : 4);
        check("active count", act_log.size(), na);
        for (int i = 0; i < act_log.size() && i < na; i++)
          check("active seq", act_log[i], 4'b0001 << i);
        if (e.exp_lat != 0)
          check("latency", cyc - start_cyc, e.exp_lat);
        if (e.stall && act_cyc.size() >= 4)
          check("L1 timeout gap", act_cyc[3] - act_cyc[2], 19);
      end
    end
  end

  task automatic load_board(vec_t v);
    int r, c;
    for (int a = 0; a < 256; a++) board[a] = 2'd0;
    for (int j = 0; j < v.llen; j++) begin
      r = int'(v.line0[7:4]) + j * dr(v.ldir);
      c = int'(v.line0[3:0]) + j * dc(v.ldir);
      board[{r[3:0], c[3:0]}] = v.chess;
    end
    board[v.ptr] = v.chess;
    stall2 = v.stall;
  endtask

  task automatic run_vec(vec_t v, bit dbl, bit fin);
    bit found;
    load_board(v);
    @(negedge clk);
    act_log.delete();
    act_cyc.delete();
    addr_log.delete();
    sb.push_back(v);
    pointer   = v.ptr;
    chess     = v.chess;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (dbl) begin
      repeat (4) @(negedge clk);
      pointer = 8'h12;
      chess   = 2'd0;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ignored start chess", chk_chess, v.chess);
      check("ignored start busy", busy, 1'b1);
    end
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL done wait: no done within 400 cycles");
    end
    if (fin) begin
      pointer = v.ptr;
      chess   = 2'd1;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("finish start ignored", busy, 1'b0);
      check("win held", win, v.exp_win);
    end
    @(negedge clk);
  endtask

  initial begin
    bit got;
    int d0;
    vecs[0]  = '{8'h53, 2'd1, 8'h51, 0, 5, 0, 1, 2'd0, 0, 11};
    vecs[1]  = '{8'h47, 2'd2, 8'h27, 1, 5, 0, 1, 2'd1, 0, 0};
    vecs[2]  = '{8'h88, 2'd1, 8'h88, 0, 0, 0, 0, 2'd0, 0, 0};
    vecs[3]  = '{8'h44, 2'd1, 8'h22, 2, 5, 0, 1, 2'd2, 0, 0};
    vecs[4]  = '{8'h75, 2'd1, 8'h93, 3, 5, 0, 1, 2'd3, 0, 0};
    vecs[5]  = '{8'h12, 2'd0, 8'h12, 0, 0, 0, 0, 2'd0, 0, 1};
    vecs[6]  = '{8'h00, 2'd2, 8'h00, 0, 5, 0, 1, 2'd0, 0, 0};
    vecs[7]  = '{8'hFF, 2'd1, 8'hBF, 1, 5, 0, 1, 2'd1, 0, 0};
    vecs[8]  = '{8'h63, 2'd1, 8'h60, 0, 4, 0, 0, 2'd0, 0, 0};
    vecs[9]  = '{8'h44, 2'd1, 8'h22, 2, 5, 1, 0, 2'd0, 1, 0};
    vecs[10] = '{8'h75, 2'd2, 8'h93, 3, 5, 1, 1, 2'd3, 1, 0};

    for (int a = 0; a < 256; a++) board[a] = 2'd0;
    stall2  = 1'b0;
    reset   = 1'b0;
    start   = 1'b0;
    pointer = 8'h00;
    chess   = 2'd0;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst win", win, 1'b0);
    check("rst win_dir", win_dir, 2'd0);
    check("rst timeout_err", timeout_err, 1'b0);
    check("rst chk_reset", chk_reset, 1'b1);
    check("rst chk_active", chk_active, 4'b0);
    check("rst mem_addr", mem_addr, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], i == 2, i == 1);
      if (i == 0) begin
        got = addr_log.size() >= 5;
        check("sweep length ok", got, 1'b1);
        if (got) begin
          check("sweep 0", addr_log[3], 8'h50);
          check("sweep 1", addr_log[4], 8'h51);
        end
      end
    end

    // Abort a run while dir 1 is scanning.
    load_board(vecs[1]);
    @(negedge clk);
    act_log.delete();
    act_cyc.delete();
    pointer = 8'h47;
    chess   = 2'd2;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (act_log.size() >= 2) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached dir 1", got, 1'b1);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort chk_reset", chk_reset, 1'b1);
    check("abort done", done, 1'b0);
    check("abort chk_active", chk_active, 4'b0);
    check("abort mem_addr", mem_addr, 8'h00);
    @(negedge clk);
    check("abort hold busy", busy, 1'b0);
    check("abort hold chk_reset", chk_reset, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("no done after abort", done_cnt, d0);
    run_vec(vecs[0], 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
